// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave with a fixed request-to-response latency,
// byte-lane stores and fault reporting for misaligned or out-of-window addresses.
module data_mem_responder #(
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2,
  parameter logic [31:0] BASE    = 32'h10010000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int          IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  LAT  = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  function automatic logic addr_ok(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE};
    return (a[1:0] == 2'b00) && (a >= BASE) && (off < SPAN);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
    return IW'((a - BASE) >> 2);
  endfunction

  state_t      state;
  logic [3:0]  cnt;
  logic        we_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [3:0]  be_p0;
  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        enter_resp;
  logic        wr_en;
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_be;

  // With zero latency the store commits on the accepting edge, so the live
  // inputs are used; otherwise the captured request drives the commit.
  always_comb begin
    accept     = req && ready && (state == IDLE);
    cur_we     = we_p0;
    cur_addr   = addr_p0;
    cur_wdata  = wdata_p0;
    cur_be     = be_p0;
    if (state == IDLE) begin
      cur_we    = we;
      cur_addr  = addr;
      cur_wdata = wdata;
      cur_be    = be;
    end
    enter_resp = (accept && (LAT == 4'd0)) || ((state == BUSY) && (cnt == 4'd1));
    wr_en      = !reset && enter_resp && cur_we && addr_ok(cur_addr);
  end

  // Stage p0: request capture (data only, no reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= we;
      addr_p0  <= addr;
      wdata_p0 <= wdata;
      be_p0    <= be;
    end
  end

  // Memory array: byte-lane commit on the edge entering RESP
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[word_idx(cur_addr)][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  // Control FSM; the response registers present RESP's result one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ready <= 1'b1;
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= LAT;
            ready <= 1'b0;
            state <= (LAT == 4'd0) ? RESP : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          state <= IDLE;
          ready <= 1'b1;
          done  <= 1'b1;
          err   <= !addr_ok(addr_p0);
          rdata <= (addr_ok(addr_p0) && !we_p0) ? mem[word_idx(addr_p0)] : '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized accesses
// against a word/byte-mask memory model. Unit 0 has LATENCY=2, unit 1 LATENCY=0.
module tb_data_mem_responder;

  localparam logic [31:0] BASE  = 32'h10010000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset [2];
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic        ready [2];
  logic        done  [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl   [int];
  logic [3:0]  kmask [int];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2), .BASE(BASE)) dut (
    .clk(clk), .reset(reset[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .be(be[0]), .ready(ready[0]), .done(done[0]),
    .rdata(rdata[0]), .err(err[0])
  );

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0), .BASE(BASE)) dut_l0 (
    .clk(clk), .reset(reset[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .be(be[1]), .ready(ready[1]), .done(done[1]),
    .rdata(rdata[1]), .err(err[1])
  );

  function automatic bit addr_valid(input logic [31:0] a);
    longint la;
    la = longint'({32'd0, a});
    return (a[1:0] == 2'b00) && (la >= longint'({32'd0, BASE})) &&
           (la < longint'({32'd0, BASE}) + 4 * DEPTH);
  endfunction

  // Reference: a word array with per-byte "known" masks.
  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] b, output logic [31:0] erd,
                              output logic eerr, output bit known);
    int          k;
    logic [31:0] cur;
    logic [3:0]  m;
    known = 1; erd = '0; eerr = 1'b0;
    if (!addr_valid(a)) begin
      eerr = 1'b1;
    end else begin
      k = int'((a - BASE) / 4);
      cur = mdl.exists(k) ? mdl[k] : 32'd0;
      m   = kmask.exists(k) ? kmask[k] : 4'h0;
      if (w) begin
        for (int i = 0; i < 4; i++) begin
          if (b[i]) begin
            cur[8*i +: 8] = d[8*i +: 8];
            m[i] = 1'b1;
          end
        end
        mdl[k] = cur;
        kmask[k] = m;
      end else if (m == 4'hF) begin
        erd = cur;
      end else begin
        known = 0;
      end
    end
  endtask

  // One access: waits for ready, scrambles inputs while busy, returns the
  // edges from acceptance to done (-1 on timeout), the response and whether
  // anything was still asserted on the cycle after done.
  task automatic do_access(input int u, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b, output int lat,
                           output logic [31:0] rd, output logic er, output logic after);
    int n;
    @(negedge clk);
    req[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d; be[u] = b;
    n = 0;
    while (ready[u] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    we[u] = 1'($urandom); addr[u] = $urandom; wdata[u] = $urandom; be[u] = 4'($urandom);
    lat = -1; rd = '0; er = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done[u] === 1'b1) begin
        lat = k; rd = rdata[u]; er = err[u];
        break;
      end
    end
    req[u] = 1'b0;
    @(posedge clk); #1;
    after = done[u] | err[u] | (|rdata[u]);
  endtask

  task automatic test_reset();
    reset[0] = 1'b1; reset[1] = 1'b1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = BASE; wdata[0] = 32'hFFFFFFFF; be[0] = 4'hF;
    req[1] = 1'b0; we[1] = 1'b0; addr[1] = BASE; wdata[1] = '0; be[1] = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready[0] !== 1'b1 || done[0] !== 1'b0 || err[0] !== 1'b0 || rdata[0] !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b done=%b err=%b rdata=%h required 1 0 0 0",
               ready[0], done[0], err[0], rdata[0]);
    end
    reset[0] = 1'b0; reset[1] = 1'b0; req[0] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready[0] !== 1'b1 || ready[1] !== 1'b1 || done[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b/%b done=%b required 1/1 0", ready[0], ready[1], done[0]);
    end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic er, af;
    do_access(0, 1'b1, 32'h10010004, 32'hDEADBEEF, 4'hF, lat, rd, er, af);
    checks++;
    if (lat != 3 || rd !== 32'd0 || er !== 1'b0 || af !== 1'b0) begin
      errors++;
      $display("FAIL store_full: lat=%0d rdata=%h err=%b after=%b required 3 0 0 0", lat, rd, er, af);
    end
    do_access(0, 1'b0, 32'h10010004, 32'h0, 4'h0, lat, rd, er, af);
    checks++;
    if (lat != 3 || rd !== 32'hDEADBEEF || er !== 1'b0 || af !== 1'b0) begin
      errors++;
      $display("FAIL load_full: lat=%0d rdata=%h err=%b after=%b required 3 deadbeef 0 0", lat, rd, er, af);
    end
  endtask

  task automatic test_byte_enable();
    int lat; logic [31:0] rd; logic er, af;
    do_access(0, 1'b1, 32'h10010004, 32'h000000AA, 4'h1, lat, rd, er, af);
    do_access(0, 1'b0, 32'h10010004, 32'h0, 4'h0, lat, rd, er, af);
    checks++;
    if (rd !== 32'hDEADBEAA || er !== 1'b0) begin
      errors++;
      $display("FAIL byte_lane: rdata=%h err=%b required deadbeaa 0", rd, er);
    end
    do_access(0, 1'b1, 32'h10010004, 32'h11223344, 4'h0, lat, rd, er, af);
    checks++;
    if (lat != 3 || er !== 1'b0 || rd !== 32'd0) begin
      errors++;
      $display("FAIL be_zero_store: lat=%0d err=%b rdata=%h required 3 0 0", lat, er, rd);
    end
    do_access(0, 1'b0, 32'h10010004, 32'h0, 4'h0, lat, rd, er, af);
    checks++;
    if (rd !== 32'hDEADBEAA) begin
      errors++;
      $display("FAIL be_zero_unchanged: rdata=%h required deadbeaa", rd);
    end
  endtask

  task automatic test_invalid();
    int lat; logic [31:0] rd; logic er, af;
    logic [31:0] bad [4];
    bad[0] = 32'h10010006; bad[1] = 32'h10011000; bad[2] = 32'h1000FFFC; bad[3] = 32'h10010005;
    for (int i = 0; i < 4; i++) begin
      do_access(0, (i >= 2), bad[i], 32'h55555555, 4'hF, lat, rd, er, af);
      checks++;
      if (lat != 3 || er !== 1'b1 || rd !== 32'd0 || af !== 1'b0) begin
        errors++;
        $display("FAIL invalid_addr %h: lat=%0d err=%b rdata=%h after=%b required 3 1 0 0",
                 bad[i], lat, er, rd, af);
      end
    end
    do_access(0, 1'b0, 32'h10010004, 32'h0, 4'h0, lat, rd, er, af);
    checks++;
    if (rd !== 32'hDEADBEAA || er !== 1'b0) begin
      errors++;
      $display("FAIL invalid_no_write: rdata=%h err=%b required deadbeaa 0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc [$];
    int done_cyc [$];
    int nready;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10010004; be[0] = 4'h0;
    nready = 0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      if (ready[0] === 1'b1) begin
        acc_cyc.push_back(c);
        nready++;
      end
      @(posedge clk); #1;
      if (c == 23) req[0] = 1'b0;
      if (done[0] === 1'b1) done_cyc.push_back(c);
    end
    checks++;
    if (acc_cyc.size() != 6 || done_cyc.size() != 6 || nready != 6) begin
      errors++;
      $display("FAIL b2b_counts: accepts=%0d dones=%0d ready_cycles=%0d required 6 6 6",
               acc_cyc.size(), done_cyc.size(), nready);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (acc_cyc[i] != 4 * i || done_cyc[i] != 4 * i + 3) begin
          errors++;
          $display("FAIL b2b_timing[%0d]: accept=%0d done=%0d required %0d %0d",
                   i, acc_cyc[i], done_cyc[i], 4 * i, 4 * i + 3);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic er, af;
    logic seen;
    do_access(0, 1'b1, 32'h10010008, 32'h0BADF00D, 4'hF, lat, rd, er, af);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10010008; wdata[0] = 32'h12345678; be[0] = 4'hF;
    @(posedge clk); #1;
    req[0] = 1'b0; reset[0] = 1'b1;
    @(posedge clk); #1;
    reset[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      seen = seen | done[0];
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done seen=%b required 0", seen);
    end
    do_access(0, 1'b0, 32'h10010008, 32'h0, 4'h0, lat, rd, er, af);
    checks++;
    if (lat != 3 || rd !== 32'h0BADF00D || er !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_commit: lat=%0d rdata=%h err=%b required 3 0badf00d 0", lat, rd, er);
    end
  endtask

  task automatic test_latency_zero();
    int lat; logic [31:0] rd; logic er, af;
    logic [31:0] v;
    v = $urandom;
    do_access(1, 1'b1, 32'h10010FFC, v, 4'hF, lat, rd, er, af);
    checks++;
    if (lat != 1 || er !== 1'b0 || rd !== 32'd0 || af !== 1'b0) begin
      errors++;
      $display("FAIL l0_store: lat=%0d err=%b rdata=%h after=%b required 1 0 0 0", lat, er, rd, af);
    end
    do_access(1, 1'b0, 32'h10010FFC, 32'h0, 4'h0, lat, rd, er, af);
    checks++;
    if (lat != 1 || rd !== v || er !== 1'b0) begin
      errors++;
      $display("FAIL l0_load: lat=%0d rdata=%h err=%b required 1 %h 0", lat, rd, er, v);
    end
    do_access(1, 1'b0, 32'h10011000, 32'h0, 4'h0, lat, rd, er, af);
    checks++;
    if (lat != 1 || rd !== 32'd0 || er !== 1'b1) begin
      errors++;
      $display("FAIL l0_range: lat=%0d rdata=%h err=%b required 1 0 1", lat, rd, er);
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd; logic er, af;
    logic [31:0] a, d, erd;
    logic w, eerr;
    logic [3:0] b;
    bit known;
    for (int i = 0; i < 56; i++) begin
      a = BASE + 32'(4 * (32 + (i % 16)));
      w = 1'b1; b = 4'hF; d = $urandom;
      if (i >= 16) begin
        a = BASE + 32'(4 * (32 + $urandom_range(0, 15)));
        w = 1'($urandom); b = 4'($urandom); d = $urandom;
        case ($urandom_range(0, 9))
          0: a = a + 32'($urandom_range(1, 3));
          1: a = BASE - 32'(4 * $urandom_range(1, 8));
          2: a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
          default: ;
        endcase
      end
      model_access(w, a, d, b, erd, eerr, known);
      do_access(0, w, a, d, b, lat, rd, er, af);
      checks++;
      if (lat != 3 || er !== eerr || (known && rd !== erd) || af !== 1'b0) begin
        errors++;
        $display("FAIL random[%0d] we=%b addr=%h be=%h: lat=%0d err=%b rdata=%h after=%b required 3 %b %h 0",
                 i, w, a, b, lat, er, rd, af, eerr, erd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_invalid();
    test_back_to_back();
    test_reset_abort();
    test_latency_zero();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DEPTH, 1024, number of 32-bit words stored
  LATENCY, 2, wait cycles between request acceptance and response (0..15)
  BASE, 32'h10010000, byte address of word 0
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk    input   1   single clock; all state updates on rising edge
  reset  input   1   synchronous, active-high reset
  req    input   1   initiator requests an access
  we     input   1   1 = store, 0 = load
  addr   input   32  byte address
  wdata  input   32  store data
  be     input   4   byte enables for stores; be[i] covers wdata[8i+7:8i]
  ready  output  1   responder can accept a request this cycle
  done   output  1   one-cycle response strobe
  rdata  output  32  load data, valid while done=1
  err    output  1   access fault, valid while done=1

Function
REQ-003 The block SHALL use three states: IDLE, BUSY and RESP.
REQ-004 ready SHALL be 1 in IDLE and 0 in BUSY and RESP.
REQ-005 A request SHALL be accepted on a rising edge when req=1 and ready=1.
REQ-006 On acceptance, the block SHALL capture we, addr, wdata and be, and load the wait counter with LATENCY.
REQ-007 From IDLE, acceptance SHALL go to BUSY when LATENCY>0 and to RESP when LATENCY=0.
REQ-008 In BUSY the counter SHALL decrement by 1 each cycle; the state SHALL move to RESP on the edge where the counter goes from 1 to 0.
REQ-009 If acceptance occurs at edge T, done SHALL be 1 for exactly the cycle following edge T+LATENCY+1 and 0 at all other times.
REQ-010 RESP SHALL last one cycle and then return to IDLE.
REQ-011 A new request SHALL be acceptable on the first edge after RESP; maximum throughput is one access per LATENCY+2 cycles.
REQ-012 req and all other inputs SHALL be ignored in BUSY and RESP; only the captured values are used.
REQ-013 An address SHALL be valid iff addr[1:0]=0 and BASE <= addr < BASE+4*DEPTH.
REQ-014 For a valid address, the word index SHALL be (addr-BASE)>>2, computed in 32-bit unsigned arithmetic.
REQ-015 A valid store SHALL update only the byte lanes with be[i]=1, on the edge entering RESP; lanes with be[i]=0 SHALL be unchanged.
REQ-016 A store with be=4'b0000 SHALL complete normally (done=1, err=0) and leave memory unchanged.
REQ-017 A valid load SHALL drive rdata with the full stored word during RESP; be SHALL be ignored for loads.
REQ-018 For stores, rdata SHALL be 0 during RESP.
REQ-019 For an invalid address, the block SHALL perform no array access, set err=1 and rdata=0 during RESP, and still give done with normal latency.
REQ-020 Outside RESP, err and rdata SHALL be 0.
REQ-021 A load immediately following a store to the same word SHALL return the new data.

Reset
REQ-022 While reset=1 at a rising edge, the state SHALL become IDLE, the counter 0, done=0, err=0 and rdata=0.
REQ-023 ready SHALL be 1 in the first cycle after reset is released.
REQ-024 Reset SHALL take priority over a simultaneous req=1; the request SHALL not be accepted.
REQ-025 Reset during BUSY SHALL abort the access; a pending store SHALL not be committed, and no done SHALL be produced for it.
REQ-026 Memory contents SHALL not be cleared by reset; loads of never-written words return undefined data.

Verification
REQ-027 The bench SHALL cover the following directed scenarios (LATENCY=2, BASE=32'h10010000, DEPTH=1024):
  - Store 32'hDEADBEEF to 32'h10010004 with be=4'hF, then load 32'h10010004 -> done 3 cycles after each acceptance; load returns rdata=32'hDEADBEEF, err=0.
  - Store 32'h000000AA to 32'h10010004 with be=4'h1, then load it -> rdata=32'hDEADBEAA.
  - Load 32'h10010006 (misaligned), then load 32'h10011000 (out of range) -> each gives done with err=1, rdata=0; memory unchanged.
  - Hold req=1 continuously over back-to-back loads -> ready=0 in BUSY and RESP; exactly one acceptance per 4 cycles; one done per access.
  - Assert reset one cycle after accepting a store of 32'h12345678 to 32'h10010008, then load that address -> no done for the aborted store; load returns the prior contents of the word.
  - With LATENCY=0, store then load 32'h10010FFC (last word) -> done 1 cycle after each acceptance; load returns the stored value.
